// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read imem,
// and hands fetched words plus PC+4 to decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcOut,
  output logic [31:0] instruction,
  output logic        valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pcQ;
  logic [31:0] pcPlus4Q;
  logic        reqValidQ;
  logic [31:0] fetchCountQ;
  logic [31:0] pcNext;
  logic        accept;

  assign pcNext      = pcQ + 32'd4;
  assign accept      = reqValidQ & ~stall & ~branch_taken;

  assign imem_addr   = pcQ;
  assign imem_re     = rst_n & ~(stall & ~branch_taken);
  assign valid       = reqValidQ;
  assign instruction = reqValidQ ? imem_rdata : 32'h0000_0000;
  assign pcOut       = pcPlus4Q;
  assign fetch_count = fetchCountQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ       <= RESET_PC;
      reqValidQ <= 1'b0;
      pcPlus4Q  <= 32'h0000_0000;
    end else if (branch_taken) begin
      // word read from the old PC this cycle is wrong-path
      pcQ       <= {branch_target[31:2], 2'b00};
      reqValidQ <= 1'b0;
    end else if (!stall) begin
      pcQ       <= pcNext;
      reqValidQ <= 1'b1;
      pcPlus4Q  <= pcNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCountQ <= 32'h0000_0000;
    end else if (accept) begin
      fetchCountQ <= fetchCountQ + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: sequential run, stall, redirect,
// stall+redirect, PC wrap, early redirect and async reset.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] pcOut;
  logic [31:0] instruction;
  logic        valid;
  logic [31:0] fetch_count;

  int nVec;
  int nBad;

  fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_re      (imem_re),
    .imem_rdata   (imem_rdata),
    .pcOut        (pcOut),
    .instruction  (instruction),
    .valid        (valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  initial imem_rdata = 32'h0;
  always @(posedge clk)
    if (imem_re) imem_rdata <= mword(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shows(input string tag,
                       input logic [31:0] a);
    chk({tag, ".ins"}, instruction, mword(a));
    chk({tag, ".pc"}, pcOut, a + 32'd4);
    chk({tag, ".v"}, {31'b0, valid}, 32'd1);
  endtask

  task automatic bubble(input string tag,
                        input logic [31:0] tgt);
    chk({tag, ".v"}, {31'b0, valid}, 32'd0);
    chk({tag, ".ins"}, instruction, 32'd0);
    chk({tag, ".addr"}, imem_addr, tgt);
  endtask

  // leaves the bench in cycle 0 (just after rst_n rises)
  task automatic doReset(input bit checkIt);
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (checkIt) begin
      chk("rst.addr", imem_addr, RPC);
      chk("rst.re", {31'b0, imem_re}, 32'd0);
      chk("rst.v", {31'b0, valid}, 32'd0);
      chk("rst.ins", instruction, 32'd0);
      chk("rst.pc", pcOut, 32'd0);
      chk("rst.cnt", fetch_count, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("c0.re", {31'b0, imem_re}, 32'd1);
    chk("c0.addr", imem_addr, RPC);
  endtask

  initial begin
    nVec = 0;
    nBad = 0;

    // sequential run
    doReset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      shows("seq", RPC + 32'(4 * i));
    end
    step();
    chk("seq.cnt", fetch_count, 32'd4);
    shows("seq5", RPC + 32'h10);

    // stall for 3 cycles while 0x400008 shown
    doReset(1'b0);
    step();
    step();
    step();
    shows("st3", RPC + 32'h8);
    chk("st3.cnt", fetch_count, 32'd2);
    stall = 1'b1;
    #1;
    chk("st3.re", {31'b0, imem_re}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      shows("stH", RPC + 32'h8);
      chk("stH.re", {31'b0, imem_re}, 32'd0);
      chk("stH.cnt", fetch_count, 32'd2);
    end
    step();
    stall = 1'b0;
    shows("st6", RPC + 32'h8);
    chk("st6.cnt", fetch_count, 32'd2);
    step();
    shows("st7", RPC + 32'hC);
    chk("st7.cnt", fetch_count, 32'd3);

    // branch while 0x400004 shown
    doReset(1'b0);
    step();
    step();
    shows("br2", RPC + 32'h4);
    branch_taken = 1'b1;
    branch_target = 32'h0040_0103;
    step();
    branch_taken = 1'b0;
    bubble("br3", 32'h0040_0100);
    chk("br3.pc", pcOut, 32'h0040_0008);
    step();
    shows("br4", 32'h0040_0100);
    chk("br4.cnt", fetch_count, 32'd1);

    // stall and branch together
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0050_0000;
    #1;
    chk("sb.re", {31'b0, imem_re}, 32'd1);
    step();
    stall = 1'b0;
    branch_taken = 1'b0;
    bubble("sb5", 32'h0050_0000);
    step();
    shows("sb6", 32'h0050_0000);

    // wrap past top of address space
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    bubble("wr7", 32'hFFFF_FFFC);
    step();
    shows("wr8", 32'hFFFF_FFFC);
    chk("wr8.pc0", pcOut, 32'd0);
    step();
    shows("wr9", 32'h0);
    chk("wr9.cnt", fetch_count, 32'd2);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.v", {31'b0, valid}, 32'd0);
    chk("ar.pc", pcOut, 32'd0);
    chk("ar.cnt", fetch_count, 32'd0);
    chk("ar.addr", imem_addr, RPC);
    chk("ar.ins", instruction, 32'd0);
    chk("ar.re", {31'b0, imem_re}, 32'd0);

    // branch in cycle 0
    doReset(1'b0);
    branch_taken = 1'b1;
    branch_target = 32'h0040_0200;
    step();
    branch_taken = 1'b0;
    bubble("eb1", 32'h0040_0200);
    chk("eb1.cnt", fetch_count, 32'd0);
    step();
    shows("eb2", 32'h0040_0200);
    chk("eb2.cnt", fetch_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode. It owns the program counter and drives a synchronous-read instruction memory. It presents each fetched instruction and its PC+4 to decode, whose inputs are `pc` and `instruction`. It handles hazard-unit stalls, branch redirects and bubble insertion, and counts instructions delivered.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and the current outputs this cycle.
- `branch_taken`  in  1  redirect request, resolved downstream.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and treated as 00.
- `imem_addr`  out  32  instruction memory read address.
- `imem_re`  out  1  instruction memory read enable.
- `imem_rdata`  in  32  memory data. It updates to M[imem_addr] at an edge where `imem_re`=1 and holds otherwise.
- `pcOut`  out  32  PC+4 of the instruction on `instruction`; drives decode `pc`.
- `instruction`  out  32  instruction to decode; 32'h0000_0000 (sll $0 NOP) when invalid.
- `valid`  out  1  `instruction` is a real fetched instruction.
- `fetch_count`  out  32  number of instructions accepted by decode.

## Operation
State:
- `pc_q`: next address to issue.
- `req_valid_q`: the word arriving on `imem_rdata` is on the correct path.
- `pc_plus4_q`: PC+4 of that word.
- `fetch_count` register.

Combinational outputs:
- `imem_addr` = `pc_q`.
- `imem_re` = `rst_n` & ~(`stall` & ~`branch_taken`).
- `valid` = `req_valid_q`.
- `instruction` = `req_valid_q` ? `imem_rdata` : 0.
- `pcOut` = `pc_plus4_q`.

Per-edge update, in priority order:
- Reset (`rst_n`=0, asynchronous): `pc_q`=RESET_PC, `req_valid_q`=0, `pc_plus4_q`=0, `fetch_count`=0.
- Redirect (`branch_taken`=1, stall ignored):
  - `pc_q` <= {`branch_target`[31:2],2'b00}.
  - `req_valid_q` <= 0. The word read this cycle from the old `pc_q` is wrong-path and is squashed.
  - `pc_plus4_q` holds.
- Stall (`stall`=1, no branch): all registers hold. Because `imem_re`=0, `imem_rdata` also holds, so every output is stable.
- Normal:
  - `pc_q` <= `pc_q`+4.
  - `req_valid_q` <= 1.
  - `pc_plus4_q` <= `pc_q`+4.
- Count: `fetch_count` increments by 1 when `valid` & ~`stall` & ~`branch_taken`.

Arithmetic and width rules:
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

The instruction shown during a `branch_taken` cycle is still latched by decode at that edge. Squashing that instruction is the responsibility of the downstream flush logic, not this block.

## Timing
- Reset outputs: `imem_addr`=RESET_PC, `imem_re`=0, `valid`=0, `instruction`=0, `pcOut`=0, `fetch_count`=0.
- First cycle after `rst_n` rises (cycle 0): `imem_re`=1 and RESET_PC is issued.
- Cycle 1: `instruction`=M[RESET_PC], `pcOut`=RESET_PC+4, `valid`=1.
- Fetch latency is 1 cycle. Steady-state throughput is 1 instruction per cycle with no bubbles.
- Redirect in cycle k:
  - Cycle k+1: `valid`=0, `instruction`=0, target issued.
  - Cycle k+2: M[target] with `pcOut`=target+4.
  - Penalty is exactly 1 bubble from this block.
- Stall asserted for N cycles: outputs are identical across all N cycles, then advance on the first non-stall edge. No instruction is lost or duplicated.
- Stall and branch in the same cycle: branch wins, `imem_re`=1, the redirect proceeds.
- Branch in the first cycle after reset (`req_valid_q`=0): redirect proceeds normally and `fetch_count` does not increment.
- Reset asserted mid-stream: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset/sequential: RESET_PC=0x0040_0000, M[k]=k-tagged words, no stall or branch.
  - Cycles 1..4 show M[0x400000..0x40000C] with `pcOut` 0x400004..0x400010.
  - `valid`=1 in every one of those cycles; `fetch_count`=4 after cycle 4.
- Stall: assert `stall` for 3 cycles while 0x400008 is shown.
  - `instruction`, `pcOut` and `valid` are unchanged for all 3 cycles and `imem_re`=0.
  - The next cycle shows 0x40000C; `fetch_count` does not increment during the stall.
- Branch: `branch_taken`=1, target 0x0040_0103 while 0x400004 is shown.
  - Next cycle: `valid`=0, `instruction`=0, `imem_addr`=0x400100.
  - Following cycle: M[0x400100] with `pcOut`=0x400104.
- Stall+branch in the same cycle, target 0x500000: redirect taken, one bubble, then M[0x500000].
- Wrap: branch to 0xFFFF_FFFC.
  - That instruction is shown with `pcOut`=0, then M[0] with `pcOut`=4.
- Async reset mid-stream: drop `rst_n` between edges.
  - `valid`, `pcOut` and `fetch_count` go to 0 and `imem_addr` to RESET_PC with no clock edge.
